// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared constants and helpers for the pipeline performance / halt monitor.
package pipeline_perf_monitor_pkg;

  localparam logic [31:0] RV_NOP     = 32'h00000013;
  localparam int          PERIOD_W   = 3;
  localparam int          HIST_DEPTH = 4;

  localparam int TH_P1_DEF = 3;
  localparam int TH_P2_DEF = 4;
  localparam int TH_P3_DEF = 6;
  localparam int TH_P4_DEF = 8;

  // Shortest loop period wins when several detectors fire together.
  function automatic logic [PERIOD_W-1:0] lowest_period(input logic [HIST_DEPTH-1:0] fire);
    logic [PERIOD_W-1:0] p;
    p = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--)
      if (fire[i]) p = PERIOD_W'(i + 1);
    return p;
  endfunction

endpackage

// File: rtl/pipeline_perf_monitor_loop_match_counter.sv
// Consecutive-match counter for one loop period; fire pulses on the sample reaching TH.
module loop_match_counter
  import pipeline_perf_monitor_pkg::*;
#(
  parameter int TH = TH_P1_DEF,
  parameter int W  = $clog2(TH + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic sample,
  input  logic match,
  output logic fire
);

  logic [W-1:0] mcnt_q, mcnt_d;
  logic [W:0]   mcnt_inc;

  assign mcnt_inc = {1'b0, mcnt_q} + {{W{1'b0}}, 1'b1};
  assign fire     = sample && match && (mcnt_inc == (W + 1)'(TH));

  always_comb begin
    mcnt_d = mcnt_q;
    if (sample) mcnt_d = match ? mcnt_inc[W-1:0] : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   mcnt_q <= '0;
    else if (clear) mcnt_q <= '0;
    else            mcnt_q <= mcnt_d;
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle/instruction counters with PC-loop halt detection (periods 1-4).
// Optional stall/NOP counters are enabled by defining PERF_STALL_CNT_EN.
module pipeline_perf_monitor
  import pipeline_perf_monitor_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TH_P1 = TH_P1_DEF,
  parameter int TH_P2 = TH_P2_DEF,
  parameter int TH_P3 = TH_P3_DEF,
  parameter int TH_P4 = TH_P4_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                run,
  input  logic                clear,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         instr_in,
  input  logic                stall_in,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_count,
  output logic                halted,
  output logic [PERIOD_W-1:0] halt_period,
`ifdef PERF_STALL_CNT_EN
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    nop_count,
`endif
  output logic [31:0]         halt_pc
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_ONE : v;
  endfunction

  logic [CNT_W-1:0]    cycle_q, instr_q;
  logic                halted_q;
  logic [PERIOD_W-1:0] period_q;
  logic [31:0]         halt_pc_q;
  logic [31:0]         hist_q [HIST_DEPTH];
  logic [2:0]          fill_q, fill_d;
  logic [31:0]         prev_instr_q;
  logic                sample, is_nop;
  logic [HIST_DEPTH-1:0] match, fire;

  assign sample = run && !halted_q;
  assign is_nop = (instr_in == RV_NOP);
  assign fill_d = (fill_q == 3'(HIST_DEPTH)) ? fill_q : fill_q + 3'd1;

  always_comb begin
    for (int k = 0; k < HIST_DEPTH; k++)
      match[k] = (int'(fill_q) > k) && (pc_in == hist_q[k]);
    match[0] = match[0] && (instr_in == prev_instr_q);
  end

  for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_mcnt
    localparam int TH = (g == 0) ? TH_P1 : (g == 1) ? TH_P2 : (g == 2) ? TH_P3 : TH_P4;
    loop_match_counter #(.TH(TH)) u_mcnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .sample  (sample),
      .match   (match[g]),
      .fire    (fire[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || clear) begin
      cycle_q      <= '0;
      instr_q      <= '0;
      halted_q     <= 1'b0;
      period_q     <= '0;
      halt_pc_q    <= '0;
      fill_q       <= '0;
      prev_instr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else if (sample) begin
      cycle_q      <= sat_inc(cycle_q, 1'b1);
      instr_q      <= sat_inc(instr_q, !is_nop && !stall_in);
      fill_q       <= fill_d;
      prev_instr_q <= instr_in;
      hist_q[0]    <= pc_in;
      for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
      if (|fire) begin
        halted_q  <= 1'b1;
        period_q  <= lowest_period(fire);
        halt_pc_q <= pc_in;
      end
    end
  end

`ifdef PERF_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, nop_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || clear) begin
      stall_q <= '0;
      nop_q   <= '0;
    end else if (sample) begin
      stall_q <= sat_inc(stall_q, stall_in);
      nop_q   <= sat_inc(nop_q, is_nop && !stall_in);
    end
  end

  assign stall_count = stall_q;
  assign nop_count   = nop_q;
`else
  // Stall/NOP counters are not built in this configuration.
`endif

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign halted      = halted_q;
  assign halt_period = period_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: a 32-bit counter instance and a 4-bit saturation instance.
module tb_pipeline_perf_monitor;

  logic        clock = 1'b0;
  logic        reset_n, run, clear, stall_in;
  logic [31:0] pc_in, instr_in;

  logic [31:0] cycle_count, instr_count, halt_pc;
  logic        halted;
  logic [2:0]  halt_period;
  logic [3:0]  c4_cycle, c4_instr;
  logic        c4_halted;
  logic [2:0]  c4_period;
  logic [31:0] c4_halt_pc;
`ifdef PERF_STALL_CNT_EN
  logic [31:0] stall_count, nop_count;
  logic [3:0]  c4_stall, c4_nop;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  pipeline_perf_monitor dut (
    .clock(clock), .reset_n(reset_n), .run(run), .clear(clear),
    .pc_in(pc_in), .instr_in(instr_in), .stall_in(stall_in),
    .cycle_count(cycle_count), .instr_count(instr_count),
    .halted(halted), .halt_period(halt_period),
`ifdef PERF_STALL_CNT_EN
    .stall_count(stall_count), .nop_count(nop_count),
`endif
    .halt_pc(halt_pc)
  );

  pipeline_perf_monitor #(.CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .run(run), .clear(clear),
    .pc_in(pc_in), .instr_in(instr_in), .stall_in(stall_in),
    .cycle_count(c4_cycle), .instr_count(c4_instr),
    .halted(c4_halted), .halt_period(c4_period),
`ifdef PERF_STALL_CNT_EN
    .stall_count(c4_stall), .nop_count(c4_nop),
`endif
    .halt_pc(c4_halt_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic st);
    pc_in    = pc;
    instr_in = ins;
    stall_in = st;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(32'h0, 32'h33, 1'b0);
    clear = 1'b0;
  endtask

  logic [31:0] p3_seq [18];
  logic [31:0] ins;
  logic        st;

  initial begin
    reset_n = 1'b0; run = 1'b0; clear = 1'b0;
    pc_in = '0; instr_in = '0; stall_in = 1'b0;
    #12;
    chk("reset_cycle", 64'(cycle_count), 64'd0);
    chk("reset_instr", 64'(instr_count), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_period", 64'(halt_period), 64'd0);
    chk("reset_halt_pc", 64'(halt_pc), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    run     = 1'b1;

    // Period-1 loop
    repeat (3) step(32'h28, 32'h6F, 1'b0);
    chk("p1_not_yet", 64'(halted), 64'd0);
    step(32'h28, 32'h6F, 1'b0);
    chk("p1_halted", 64'(halted), 64'd1);
    chk("p1_period", 64'(halt_period), 64'd1);
    chk("p1_halt_pc", 64'(halt_pc), 64'h28);
    chk("p1_cycle", 64'(cycle_count), 64'd4);
    chk("p1_instr", 64'(instr_count), 64'd4);
    repeat (2) step(32'h28, 32'h6F, 1'b0);
    chk("p1_frozen_cycle", 64'(cycle_count), 64'd4);

    // Clear from halted state, then counting resumes
    do_clear();
    chk("clr_cycle", 64'(cycle_count), 64'd0);
    chk("clr_instr", 64'(instr_count), 64'd0);
    chk("clr_halted", 64'(halted), 64'd0);
    chk("clr_period", 64'(halt_period), 64'd0);
    chk("clr_halt_pc", 64'(halt_pc), 64'd0);
    step(32'h100, 32'h33, 1'b0);
    step(32'h104, 32'h33, 1'b0);
    chk("clr_resume_cycle", 64'(cycle_count), 64'd2);
    do_clear();

    // Period-2 loop after a straight-line prologue
    step(32'h0, 32'h33, 1'b0);
    step(32'h4, 32'h33, 1'b0);
    step(32'h8, 32'h33, 1'b0);
    step(32'hC, 32'h33, 1'b0);
    for (int i = 0; i < 5; i++) step((i % 2 == 0) ? 32'h10 : 32'h14, 32'h33, 1'b0);
    chk("p2_not_yet", 64'(halted), 64'd0);
    step(32'h14, 32'h33, 1'b0);
    chk("p2_halted", 64'(halted), 64'd1);
    chk("p2_period", 64'(halt_period), 64'd2);
    chk("p2_halt_pc", 64'(halt_pc), 64'h14);
    chk("p2_cycle", 64'(cycle_count), 64'd10);
    chk("p2_instr", 64'(instr_count), 64'd10);
    repeat (3) step(32'h10, 32'h33, 1'b0);
    chk("p2_instr_frozen", 64'(instr_count), 64'd10);
    do_clear();

    // 20 samples, 5 NOPs, 3 stalls, run dropped for 3 cycles mid-way
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        run = 1'b0;
        repeat (3) step(32'h900, 32'h33, 1'b0);
        chk("run_low_hold", 64'(cycle_count), 64'd10);
        run = 1'b1;
      end
      ins = (i == 2 || i == 5 || i == 9 || i == 13 || i == 17) ? 32'h13 : 32'h33;
      st  = (i == 3 || i == 11 || i == 15);
      step(32'h200 + 32'(4 * i), ins, st);
    end
    chk("mix_instr", 64'(instr_count), 64'd12);
    chk("mix_cycle", 64'(cycle_count), 64'd20);
    chk("mix_halted", 64'(halted), 64'd0);
    chk("sat4_cycle", 64'(c4_cycle), 64'hF);
    chk("sat4_instr", 64'(c4_instr), 64'hC);
`ifdef PERF_STALL_CNT_EN
    chk("mix_stall", 64'(stall_count), 64'd3);
    chk("mix_nop", 64'(nop_count), 64'd5);
`endif
    repeat (5) step(32'h400, 32'h33, 1'b0);
    chk("sat4_instr_hold", 64'(c4_instr), 64'hF);
    do_clear();

    // Period-3 loop broken after 5 matches, then 6 uninterrupted matches
    p3_seq = '{32'h40, 32'h44, 32'h48, 32'h40, 32'h44, 32'h48, 32'h40, 32'h44, 32'h50,
               32'h40, 32'h44, 32'h48, 32'h40, 32'h44, 32'h48, 32'h40, 32'h44, 32'h48};
    for (int i = 0; i < 18; i++) begin
      step(p3_seq[i], 32'h33, 1'b0);
      if (i == 8)  chk("p3_interrupt", 64'(halted), 64'd0);
      if (i == 11) chk("p3_restart", 64'(halted), 64'd0);
      if (i == 16) chk("p3_five_more", 64'(halted), 64'd0);
    end
    chk("p3_halted", 64'(halted), 64'd1);
    chk("p3_period", 64'(halt_period), 64'd3);
    chk("p3_halt_pc", 64'(halt_pc), 64'h48);
    chk("p3_cycle", 64'(cycle_count), 64'd18);

    // Asynchronous reset while halted, between clock edges
    reset_n = 1'b0;
    #2;
    chk("areset_halted", 64'(halted), 64'd0);
    chk("areset_period", 64'(halt_period), 64'd0);
    chk("areset_halt_pc", 64'(halt_pc), 64'd0);
    chk("areset_cycle", 64'(cycle_count), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(32'h500, 32'h33, 1'b0);
    chk("post_reset_cycle", 64'(cycle_count), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
